// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_t : controller FSM encodings (RUN/LU_STALL/FLUSH/MEM_WAIT)
//   REG_ZERO     : architectural zero register, never a real dependency
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// Produces per-stage enables plus IF/ID flush and ID/EX bubble strobes for
// load-use stalls, EX-resolved redirects (with a fetch-shadow squash window)
// and data-memory wait freezes.
//
// Parameters:
//   FLUSH_CYCLES : extra cycles after a redirect in which IF/ID is squashed (0..15)
//   CNT_W        : width of the performance counters
// Optional feature macro:
//   HAZ_PERF_CNT_EN : enables saturating stall_cnt / flush_cnt counters;
//                     when undefined both outputs are tied to zero.
// Ports:
//   clock, reset                       : posedge clock, async active-high reset
//   id_valid, id_rs, id_rt, id_uses_rt : instruction currently in ID
//   ex_valid, ex_memread, ex_wreg      : instruction currently in EX
//   ex_redirect                        : taken branch/jump resolved in EX
//   mem_busy                           : data memory not ready, freeze pipe
//   pc_en .. memwb_en                  : stage register enables
//   ifid_flush, idex_bubble            : invalidate IF/ID / ID/EX contents
//   ctrl_state                         : current FSM state (debug)
//   stall_cnt, flush_cnt               : performance counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t state_q, state_d;
  ctrl_state_t ret_q, ret_d;
  ctrl_state_t eff_state;
  logic [3:0]  sq_q, sq_d;
  logic        lu;

  // A load in EX feeding a register read in ID; $0 never creates a dependency.
  assign lu = ex_valid && ex_memread && (ex_wreg != REG_ZERO) && id_valid &&
              ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));

  // Leaving MEM_WAIT resumes exactly where the freeze interrupted, so the
  // cycle memory becomes ready is decoded as the saved state.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  assign ctrl_state = state_q;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    sq_d        = sq_q;

    if (mem_busy) begin
      // Whole pipe frozen; redirect and load-use re-present once memory is ready.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      if (state_q != MEM_WAIT) begin
        ret_d   = state_q;
        state_d = MEM_WAIT;
      end
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      sq_d        = 4'(FLUSH_CYCLES);
      state_d     = (FLUSH_CYCLES > 0) ? FLUSH : RUN;
    end else if (eff_state == FLUSH) begin
      // Squash wrong-path fetches still arriving; load-use is moot here.
      ifid_flush = 1'b1;
      if (sq_q != 4'd0) begin
        sq_d = sq_q - 4'd1;
      end
      state_d = (sq_q <= 4'd1) ? RUN : FLUSH;
    end else if ((eff_state == RUN) && lu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = LU_STALL;
    end else begin
      state_d = RUN;
    end

    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      sq_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      sq_q    <= sq_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Only the load-use branch moves the FSM into LU_STALL, so that transition
  // marks a stall cycle; an accepted redirect is one not masked by mem_busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((state_d == LU_STALL) && (state_q != LU_STALL) && !(&stall_q)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (ex_redirect && !mem_busy && !(&flush_q)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl, built with FLUSH_CYCLES=2.
// Each scenario task queues per-cycle stimulus with its expected outputs,
// then replays it: inputs change just after the falling edge and outputs are
// sampled 1 time unit later, well before the next rising edge.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 16;

  // Expected enable patterns: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en}
  localparam logic [6:0] NORMAL = 7'b1101011;
  localparam logic [6:0] STALL  = 7'b0001111;
  localparam logic [6:0] REDIR  = 7'b1111111;
  localparam logic [6:0] FLSH   = 7'b1111011;
  localparam logic [6:0] FROZEN = 7'b0000000;
  localparam logic [6:0] RSTO   = 7'b0010100;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             id_valid = 1'b0;
  logic [4:0]       id_rs = '0;
  logic [4:0]       id_rt = '0;
  logic             id_uses_rt = 1'b0;
  logic             ex_valid = 1'b0;
  logic             ex_memread = 1'b0;
  logic [4:0]       ex_wreg = '0;
  logic             ex_redirect = 1'b0;
  logic             mem_busy = 1'b0;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       idv;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       exv;
    logic       mr;
    logic [4:0] wr;
    logic       redir;
    logic       busy;
    logic [1:0] st;
    logic [6:0] en;
  } step_t;

  step_t      stim[$];
  string      names[$];
  logic [8:0] sb[$];

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic void add(string nm, logic idv, logic [4:0] rs, logic [4:0] rt, logic urt,
                              logic exv, logic mr, logic [4:0] wr, logic redir, logic busy,
                              logic [1:0] st, logic [6:0] en);
    step_t s;
    s.idv = idv; s.rs = rs; s.rt = rt; s.urt = urt; s.exv = exv; s.mr = mr;
    s.wr = wr; s.redir = redir; s.busy = busy; s.st = st; s.en = en;
    stim.push_back(s);
    names.push_back(nm);
  endfunction

  function automatic void add_idle(string nm, logic [1:0] st, logic [6:0] en);
    add(nm, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, st, en);
  endfunction

  task automatic apply(input step_t s);
    id_valid = s.idv; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt;
    ex_valid = s.exv; ex_memread = s.mr; ex_wreg = s.wr;
    ex_redirect = s.redir; mem_busy = s.busy;
  endtask

  function automatic logic [8:0] observed();
    return {ctrl_state, pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en};
  endfunction

  task automatic test_reset();
    logic [8:0] e;
    logic [8:0] got;
    step_t s;
    string nm;
    apply('0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    sb.push_back({2'd0, RSTO});
    #1;
    got = observed(); e = sb.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", got, e);
    end
    vectors++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    @(negedge clock);
    reset = 1'b0;
    add_idle("idle_after_reset", 2'd0, NORMAL);
    add_idle("idle_after_reset2", 2'd0, NORMAL);
    while (stim.size() != 0) begin
      s = stim.pop_front(); nm = names.pop_front();
      @(negedge clock); apply(s); sb.push_back({s.st, s.en});
      #1; got = observed(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL %s: got %b expected %b", nm, got, e);
      end
    end
  endtask

  task automatic test_load_use();
    logic [8:0] e;
    logic [8:0] got;
    step_t s;
    string nm;
    add("lu_rs",          1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0, 2'd0, STALL);
    add("lu_stall_cycle", 1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0, 2'd1, NORMAL);
    add_idle("lu_back_run", 2'd0, NORMAL);
    add("lu_rt",          1, 5'd3, 5'd9, 1, 1, 1, 5'd9, 0, 0, 2'd0, STALL);
    add_idle("lu_rt_after", 2'd1, NORMAL);
    add_idle("lu_rt_run",   2'd0, NORMAL);
    while (stim.size() != 0) begin
      s = stim.pop_front(); nm = names.pop_front();
      @(negedge clock); apply(s); sb.push_back({s.st, s.en});
      #1; got = observed(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL %s: got %b expected %b", nm, got, e);
      end
    end
  endtask

  task automatic test_no_hazard();
    logic [8:0] e;
    logic [8:0] got;
    step_t s;
    string nm;
    add("nh_reg_zero",   1, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 2'd0, NORMAL);
    add("nh_rt_unused",  1, 5'd3, 5'd7, 0, 1, 1, 5'd7, 0, 0, 2'd0, NORMAL);
    add("nh_not_load",   1, 5'd5, 5'd0, 0, 1, 0, 5'd5, 0, 0, 2'd0, NORMAL);
    add("nh_ex_invalid", 1, 5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 0, 2'd0, NORMAL);
    add("nh_id_invalid", 0, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0, 2'd0, NORMAL);
    while (stim.size() != 0) begin
      s = stim.pop_front(); nm = names.pop_front();
      @(negedge clock); apply(s); sb.push_back({s.st, s.en});
      #1; got = observed(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL %s: got %b expected %b", nm, got, e);
      end
    end
  endtask

  task automatic test_redirect();
    logic [8:0] e;
    logic [8:0] got;
    step_t s;
    string nm;
    add("rd_pulse", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 2'd0, REDIR);
    add_idle("rd_flush1", 2'd2, FLSH);
    add("rd_flush2_lu_ignored", 1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0, 2'd2, FLSH);
    add_idle("rd_run", 2'd0, NORMAL);
    add("rd_reload_first", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 2'd0, REDIR);
    add_idle("rd_reload_f1", 2'd2, FLSH);
    add("rd_reload_again", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 2'd2, REDIR);
    add_idle("rd_reload_f2", 2'd2, FLSH);
    add_idle("rd_reload_f3", 2'd2, FLSH);
    add_idle("rd_reload_run", 2'd0, NORMAL);
    while (stim.size() != 0) begin
      s = stim.pop_front(); nm = names.pop_front();
      @(negedge clock); apply(s); sb.push_back({s.st, s.en});
      #1; got = observed(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL %s: got %b expected %b", nm, got, e);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [8:0] e;
    logic [8:0] got;
    step_t s;
    string nm;
    add("mw_redirect", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 2'd0, REDIR);
    add_idle("mw_flush_a", 2'd2, FLSH);
    add("mw_busy1", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 2'd2, FROZEN);
    add("mw_busy2", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 2'd3, FROZEN);
    add("mw_busy3", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 2'd3, FROZEN);
    add("mw_busy4", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 2'd3, FROZEN);
    add_idle("mw_resume_flush", 2'd3, FLSH);
    add_idle("mw_run", 2'd0, NORMAL);
    add("mw_lu", 1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0, 2'd0, STALL);
    add("mw_busy_in_lustall", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 2'd1, FROZEN);
    add("mw_busy_hold", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 2'd3, FROZEN);
    add_idle("mw_resume_lustall", 2'd3, NORMAL);
    add_idle("mw_run2", 2'd0, NORMAL);
    while (stim.size() != 0) begin
      s = stim.pop_front(); nm = names.pop_front();
      @(negedge clock); apply(s); sb.push_back({s.st, s.en});
      #1; got = observed(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL %s: got %b expected %b", nm, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e;
    logic [8:0] got;
    step_t s;
    string nm;
    add("all3_freeze",  1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 1, 1, 2'd0, FROZEN);
    add("all3_hold",    1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 1, 1, 2'd3, FROZEN);
    add("all3_redir",   1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 1, 0, 2'd3, REDIR);
    add("all3_flush1",  1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0, 2'd2, FLSH);
    add("all3_flush2",  1, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0, 0, 2'd2, FLSH);
    add_idle("all3_run", 2'd0, NORMAL);
    while (stim.size() != 0) begin
      s = stim.pop_front(); nm = names.pop_front();
      @(negedge clock); apply(s); sb.push_back({s.st, s.en});
      #1; got = observed(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL %s: got %b expected %b", nm, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [8:0] e;
    logic [8:0] got;
    step_t s;
    string nm;
    add("rmf_redirect", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 2'd0, REDIR);
    add_idle("rmf_flush", 2'd2, FLSH);
    while (stim.size() != 0) begin
      s = stim.pop_front(); nm = names.pop_front();
      @(negedge clock); apply(s); sb.push_back({s.st, s.en});
      #1; got = observed(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL %s: got %b expected %b", nm, got, e);
      end
    end
    // Assert reset between clock edges: state must clear with no edge.
    @(negedge clock);
    reset = 1'b1;
    sb.push_back({2'd0, RSTO});
    #1;
    got = observed(); e = sb.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL rmf_async_reset: got %b expected %b", got, e);
    end
    vectors++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      miscompares++;
      $display("[TB] FAIL rmf_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    @(negedge clock);
    reset = 1'b0;
    add_idle("rmf_run_after", 2'd0, NORMAL);
    add("rmf_lu_after", 1, 5'd4, 5'd0, 0, 1, 1, 5'd4, 0, 0, 2'd0, STALL);
    add_idle("rmf_lu_release", 2'd1, NORMAL);
    while (stim.size() != 0) begin
      s = stim.pop_front(); nm = names.pop_front();
      @(negedge clock); apply(s); sb.push_back({s.st, s.en});
      #1; got = observed(); e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL %s: got %b expected %b", nm, got, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect();
    test_mem_wait();
    test_back_to_back();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
